// File: rtl/tia_phase_seq.sv
// tia_phase_seq: two-phase non-overlapping clock sequencer with a 6-bit
// polynomial (XNOR-feedback shift) counter that advances once per full
// phase cycle. The counter restarts from zero after reaching TERM, emitting
// a one-cycle wrap pulse. All outputs are registered; reset is asynchronous.
module tia_phase_seq #(
    parameter logic [5:0] TERM = 6'b010100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rsync,
    output logic       phi1,
    output logic       phi2,
    output logic [5:0] count,
    output logic       wrap,
    output logic [1:0] phase
);

    // Encodings are visible on the phase debug port, so they are fixed.
    typedef enum logic [1:0] {
        P1 = 2'd0,
        G1 = 2'd1,
        P2 = 2'd2,
        G2 = 2'd3
    } phase_t;

    // The all-ones pattern is the XNOR shift register's lockup state.
    localparam logic [5:0] LOCKUP = 6'b111111;

    phase_t     state_q;
    phase_t     state_d;
    logic [5:0] count_d;
    logic       wrap_d;

    // Counter successor: shift left, feed back XNOR of the two top bits.
    function automatic logic [5:0] poly_step(input logic [5:0] c);
        return {c[4:0], ~(c[5] ^ c[4])};
    endfunction

    // Next-state and next-count decode; rsync wins over en and the TERM rule.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        state_d = state_q;
        count_d = count;
        wrap_d  = 1'b0;

        if (rsync) begin
            // Park in G2 so the next enabled edge enters P1 cleanly.
            state_d = G2;
            count_d = '0;
        end else if (en) begin
            case (state_q)
                P1: state_d = G1;
                G1: state_d = P2;
                P2: begin
                    state_d = G2;
                    // Counter advances only on the edge leaving P2.
                    if (count == LOCKUP) begin
                        count_d = '0;
                    end else if (count == TERM) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = poly_step(count);
                    end
                end
                G2:      state_d = P1;
                default: state_d = G2;
            endcase
        end
    end

    // State, count and registered phase/wrap outputs; reset forces G2 idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= G2;
            phi1    <= 1'b0;
            phi2    <= 1'b0;
            count   <= '0;
            wrap    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            // Phase clocks are decoded from the next state so they are
            // flop outputs aligned exactly with state_q.
            phi1    <= (state_d == P1);
            phi2    <= (state_d == P2);
            count   <= count_d;
            wrap    <= wrap_d;
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_tia_phase_seq.sv
// Directed and randomized bench for tia_phase_seq. Two instances share the
// stimulus: one with the default TERM, one with TERM=000111 for wrap tests.
`timescale 1ns/1ps
module tb_tia_phase_seq;

    localparam logic [5:0] TERM_D = 6'b010100;
    localparam logic [5:0] TERM_T = 6'b000111;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       rsync;
    logic       phi1_d, phi2_d, wrap_d;
    logic [5:0] count_d;
    logic [1:0] phase_d;
    logic       phi1_t, phi2_t, wrap_t;
    logic [5:0] count_t;
    logic [1:0] phase_t;

    int n_cmp  = 0;
    int n_fail = 0;

    tia_phase_seq #(.TERM(TERM_D)) dut_d (
        .clk(clk), .reset(reset), .en(en), .rsync(rsync),
        .phi1(phi1_d), .phi2(phi2_d), .count(count_d), .wrap(wrap_d), .phase(phase_d)
    );

    tia_phase_seq #(.TERM(TERM_T)) dut_t (
        .clk(clk), .reset(reset), .en(en), .rsync(rsync),
        .phi1(phi1_t), .phi2(phi2_t), .count(count_t), .wrap(wrap_t), .phase(phase_t)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // One rising edge, then settle 1 ns so samples sit away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        rsync = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        rsync = 1'b0;
        #1;
        n_cmp++;
        if ({phase_d, phi1_d, phi2_d, count_d, wrap_d} !== {2'd3, 1'b0, 1'b0, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: phase=%0d phi1=%b phi2=%b count=%b wrap=%b, want 3 0 0 000000 0",
                     phase_d, phi1_d, phi2_d, count_d, wrap_d);
        end
        // Reset must dominate en and rsync across clock edges.
        en    = 1'b1;
        rsync = 1'b1;
        tick();
        tick();
        en = 1'b1;
        rsync = 1'b0;
        tick();
        n_cmp++;
        if ({phase_d, phi1_d, phi2_d, count_d, wrap_d} !== {2'd3, 1'b0, 1'b0, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_override: phase=%0d phi1=%b phi2=%b count=%b wrap=%b, want 3 0 0 000000 0",
                     phase_d, phi1_d, phi2_d, count_d, wrap_d);
        end
        reset = 1'b0;
        en    = 1'b0;
    endtask

    // 16 enabled edges from the reset state on the default instance.
    task automatic run_sequence(input string tag);
        logic [5:0] cnt_tab [5];
        logic [1:0] ph_tab  [4];
        logic       e_phi1, e_phi2;
        logic [1:0] e_phase;
        logic [5:0] e_count;
        cnt_tab = '{6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111};
        ph_tab  = '{2'd3, 2'd0, 2'd1, 2'd2};
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            e_phi1  = (i % 4 == 1);
            e_phi2  = (i % 4 == 3);
            e_phase = ph_tab[i % 4];
            e_count = cnt_tab[i / 4];
            n_cmp++;
            if ({phi1_d, phi2_d, phase_d, count_d, wrap_d} !== {e_phi1, e_phi2, e_phase, e_count, 1'b0}) begin
                n_fail++;
                $display("FAIL %s edge %0d: phi1=%b phi2=%b phase=%0d count=%b wrap=%b, want %b %b %0d %b 0",
                         tag, i, phi1_d, phi2_d, phase_d, count_d, wrap_d,
                         e_phi1, e_phi2, e_phase, e_count);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_sequence();
        do_reset();
        run_sequence("sequence");
    endtask

    task automatic test_wrap();
        logic [5:0] e_count;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i < 4)       e_count = 6'b000000;
            else if (i < 8)  e_count = 6'b000001;
            else if (i < 12) e_count = 6'b000011;
            else if (i < 16) e_count = 6'b000111;
            else if (i < 20) e_count = 6'b000000;
            else             e_count = 6'b000001;
            n_cmp++;
            if (count_t !== e_count || wrap_t !== (i == 16)) begin
                n_fail++;
                $display("FAIL wrap edge %0d: count=%b wrap=%b, want %b %b",
                         i, count_t, wrap_t, e_count, (i == 16));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_stretch();
        int highs;
        do_reset();
        en = 1'b1;
        tick();
        highs = (phi1_d === 1'b1) ? 1 : 0;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (phi1_d === 1'b1) highs++;
            n_cmp++;
            if ({phase_d, count_d, wrap_d, phi2_d} !== {2'd0, 6'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stretch_hold %0d: phase=%0d count=%b wrap=%b phi2=%b, want 0 000000 0 0",
                         i, phase_d, count_d, wrap_d, phi2_d);
            end
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if (highs != 6 || phase_d !== 2'd1 || phi1_d !== 1'b0) begin
            n_fail++;
            $display("FAIL stretch_release: phi1 high %0d cycles phase=%0d phi1=%b, want 6 1 0",
                     highs, phase_d, phi1_d);
        end
        en = 1'b0;
    endtask

    task automatic test_rsync();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        n_cmp++;
        if (phi2_d !== 1'b1 || count_d !== 6'b001111 || phase_d !== 2'd2) begin
            n_fail++;
            $display("FAIL rsync_setup: phi2=%b count=%b phase=%0d, want 1 001111 2",
                     phi2_d, count_d, phase_d);
        end
        en    = 1'b0;
        rsync = 1'b1;
        tick();
        rsync = 1'b0;
        n_cmp++;
        if ({phase_d, phi1_d, phi2_d, count_d, wrap_d} !== {2'd3, 1'b0, 1'b0, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rsync_pulse: phase=%0d phi1=%b phi2=%b count=%b wrap=%b, want 3 0 0 000000 0",
                     phase_d, phi1_d, phi2_d, count_d, wrap_d);
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if (phi1_d !== 1'b1 || phase_d !== 2'd0) begin
            n_fail++;
            $display("FAIL rsync_restart: phi1=%b phase=%0d, want 1 0", phi1_d, phase_d);
        end
        // rsync held high with en high keeps the block parked.
        rsync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({phase_d, phi1_d, phi2_d, count_d} !== {2'd3, 1'b0, 1'b0, 6'd0}) begin
                n_fail++;
                $display("FAIL rsync_held %0d: phase=%0d phi1=%b phi2=%b count=%b, want 3 0 0 000000",
                         i, phase_d, phi1_d, phi2_d, count_d);
            end
        end
        rsync = 1'b0;
        en    = 1'b0;
    endtask

    // rsync on the same edge where dut_t would hit TERM and wrap.
    task automatic test_rsync_priority();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (count_t !== TERM_T || phase_t !== 2'd2) begin
            n_fail++;
            $display("FAIL prio_setup: count=%b phase=%0d, want 000111 2", count_t, phase_t);
        end
        rsync = 1'b1;
        tick();
        rsync = 1'b0;
        n_cmp++;
        if ({phase_t, count_t, wrap_t} !== {2'd3, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_rsync: phase=%0d count=%b wrap=%b, want 3 000000 0",
                     phase_t, count_t, wrap_t);
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (phi2_d !== 1'b1 || count_d !== 6'b000111) begin
            n_fail++;
            $display("FAIL async_setup: phi2=%b count=%b, want 1 000111", phi2_d, count_d);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({phase_d, phi1_d, phi2_d, count_d, wrap_d} !== {2'd3, 1'b0, 1'b0, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: phase=%0d phi1=%b phi2=%b count=%b wrap=%b, want 3 0 0 000000 0",
                     phase_d, phi1_d, phi2_d, count_d, wrap_d);
        end
        en = 1'b0;
        tick();
        reset = 1'b0;
        run_sequence("async_restart");
    endtask

    // Randomized en/rsync against a behavioural model of both instances.
    task automatic test_random();
        int         ms   [2];
        logic [5:0] mc   [2];
        logic       mw   [2];
        logic [5:0] term [2];
        logic       prev1, prev2;
        int         wraps;
        term  = '{TERM_D, TERM_T};
        wraps = 0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k] = 3;
            mc[k] = 6'd0;
            mw[k] = 1'b0;
        end
        prev1 = 1'b0;
        prev2 = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            en    = ($urandom_range(3, 0) != 0);
            rsync = ($urandom_range(511, 0) == 0);
            for (int k = 0; k < 2; k++) begin
                mw[k] = 1'b0;
                if (rsync) begin
                    ms[k] = 3;
                    mc[k] = 6'd0;
                end else if (en) begin
                    if (ms[k] == 2) begin
                        if (mc[k] == term[k]) begin
                            mc[k] = 6'd0;
                            mw[k] = 1'b1;
                        end else if (mc[k] == 6'd63) begin
                            mc[k] = 6'd0;
                        end else begin
                            mc[k] = 6'((int'(mc[k]) * 2) % 64 + ((mc[k][5] == mc[k][4]) ? 1 : 0));
                        end
                    end
                    ms[k] = (ms[k] + 1) % 4;
                end
            end
            tick();
            if (wrap_d === 1'b1) wraps++;
            n_cmp++;
            if ({phase_d, phi1_d, phi2_d, count_d, wrap_d} !==
                {2'(ms[0]), ms[0] == 0, ms[0] == 2, mc[0], mw[0]}) begin
                n_fail++;
                $display("FAIL random_def cyc %0d: phase=%0d phi1=%b phi2=%b count=%b wrap=%b, want %0d %b %b %b %b",
                         cyc, phase_d, phi1_d, phi2_d, count_d, wrap_d,
                         ms[0], ms[0] == 0, ms[0] == 2, mc[0], mw[0]);
            end
            n_cmp++;
            if ({phase_t, count_t, wrap_t} !== {2'(ms[1]), mc[1], mw[1]}) begin
                n_fail++;
                $display("FAIL random_term cyc %0d: phase=%0d count=%b wrap=%b, want %0d %b %b",
                         cyc, phase_t, count_t, wrap_t, ms[1], mc[1], mw[1]);
            end
            n_cmp++;
            if ((phi1_d & phi2_d) !== 1'b0 || (prev1 & phi2_d) !== 1'b0 || (prev2 & phi1_d) !== 1'b0) begin
                n_fail++;
                $display("FAIL overlap cyc %0d: phi1=%b phi2=%b prev_phi1=%b prev_phi2=%b, want no overlap",
                         cyc, phi1_d, phi2_d, prev1, prev2);
            end
            prev1 = phi1_d;
            prev2 = phi2_d;
        end
        en    = 1'b0;
        rsync = 1'b0;
        $display("random run saw %0d wrap pulses on the default instance", wraps);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        rsync = 1'b0;
        test_reset();
        test_sequence();
        test_wrap();
        test_stretch();
        test_rsync();
        test_rsync_priority();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
